// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder
// Receive side of the seven-segment display path. Samples the multiplexed
// active-low segment bus and digit enables, waits for a digit slot to settle,
// then decodes the glyph back into its 4-bit hex value.
// Optional error counter: define SEVENSEG_ERR_CNT_EN to add err_clr/err_count.
`timescale 1ns/1ps
module sevenseg_scan_decoder #(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg_n,
    input  logic [N_DIGITS-1:0]   an_n,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [N_DIGITS-1:0]   digit_valid,
    output logic [N_DIGITS-1:0]   digit_blank,
    output logic                  capture,
    output logic [2:0]            capture_idx,
    output logic                  frame_done,
    output logic                  pattern_err
`ifdef SEVENSEG_ERR_CNT_EN
    ,
    input  logic                  err_clr,
    output logic [7:0]            err_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    state_t                  state_q;
    logic [7:0]              cnt_q;
    logic [6:0]              sSeg_q;
    logic [N_DIGITS-1:0]     sAn_q;
    logic [6:0]              prevSeg_q;
    logic [N_DIGITS-1:0]     prevAn_q;
    logic [N_DIGITS-1:0]     seen_q;
    logic [4*N_DIGITS-1:0]   digits_q;
    logic [N_DIGITS-1:0]     digitValid_q;
    logic [N_DIGITS-1:0]     digitBlank_q;
    logic                    capture_q;
    logic [2:0]              captureIdx_q;
    logic                    frameDone_q;
    logic                    patternErr_q;

    logic [N_DIGITS-1:0]     anOn;
    logic [3:0]              onesCount;
    logic [2:0]              slotIdx;
    logic                    isOneHot;
    logic                    sameSample;
    logic [6:0]              segOn;
    logic [3:0]              glyphVal;
    logic                    glyphLegal;
    logic                    glyphBlank;
    logic                    glyphIllegal;
    logic                    captureNow;
    logic [N_DIGITS-1:0]     seen_d;

    assign anOn         = ~sAn_q;
    assign segOn        = ~sSeg_q;
    assign isOneHot     = (onesCount == 4'd1);
    assign sameSample   = ({sSeg_q, sAn_q} == {prevSeg_q, prevAn_q});
    assign glyphIllegal = !glyphLegal && !glyphBlank;
    assign captureNow   = (state_q == SETTLE) && sameSample && (cnt_q == STABLE_CNT);
    assign seen_d       = seen_q | anOn;

    // Register the raw bus once, and keep the previous sample for change detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sSeg_q    <= '1;
            sAn_q     <= '1;
            prevSeg_q <= '1;
            prevAn_q  <= '1;
        end else begin
            sSeg_q    <= seg_n;
            sAn_q     <= an_n;
            prevSeg_q <= sSeg_q;
            prevAn_q  <= sAn_q;
        end
    end

    // Count enabled digits and find which slot is selected when exactly one is
    always_comb begin
        onesCount = 4'd0;
        slotIdx   = 3'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (anOn[i]) begin
                onesCount = onesCount + 4'd1;
                slotIdx   = 3'(i);
            end
        end
    end

    // Map a lit-segment pattern {a..g} back to its hex value
    always_comb begin
        glyphVal   = 4'h0;
        glyphLegal = 1'b1;
        glyphBlank = 1'b0;
        case (segOn)
            7'b1111110: glyphVal = 4'h0;
            7'b0110000: glyphVal = 4'h1;
            7'b1101101: glyphVal = 4'h2;
            7'b1111001: glyphVal = 4'h3;
            7'b0110011: glyphVal = 4'h4;
            7'b1011011: glyphVal = 4'h5;
            7'b1011111: glyphVal = 4'h6;
            7'b1110000: glyphVal = 4'h7;
            7'b1111111: glyphVal = 4'h8;
            7'b1111011: glyphVal = 4'h9;
            7'b1110111: glyphVal = 4'hA;
            7'b0011111: glyphVal = 4'hB;
            7'b1001110: glyphVal = 4'hC;
            7'b0111101: glyphVal = 4'hD;
            7'b1001111: glyphVal = 4'hE;
            7'b1000111: glyphVal = 4'hF;
            7'b0000000: begin
                glyphLegal = 1'b0;
                glyphBlank = 1'b1;
            end
            default:    glyphLegal = 1'b0;
        endcase
    end

    // Settle FSM; a slot is captured once its sample has stayed identical long enough
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            seen_q       <= '0;
            digits_q     <= '0;
            digitValid_q <= '0;
            digitBlank_q <= '0;
            capture_q    <= 1'b0;
            captureIdx_q <= 3'd0;
            frameDone_q  <= 1'b0;
            patternErr_q <= 1'b0;
        end else begin
            capture_q    <= 1'b0;
            frameDone_q  <= 1'b0;
            patternErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (isOneHot) begin
                        state_q <= SETTLE;
                        cnt_q   <= 8'd1;
                    end
                end
                SETTLE: begin
                    if (!sameSample) begin
                        if (isOneHot) begin
                            cnt_q <= 8'd1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (captureNow) begin
                        state_q      <= HELD;
                        capture_q    <= 1'b1;
                        captureIdx_q <= slotIdx;
                        patternErr_q <= glyphIllegal;
                        for (int i = 0; i < N_DIGITS; i++) begin
                            if (anOn[i]) begin
                                if (glyphLegal) begin
                                    digits_q[4*i +: 4] <= glyphVal;
                                    digitValid_q[i]    <= 1'b1;
                                    digitBlank_q[i]    <= 1'b0;
                                end else if (glyphBlank) begin
                                    digits_q[4*i +: 4] <= 4'h0;
                                    digitValid_q[i]    <= 1'b0;
                                    digitBlank_q[i]    <= 1'b1;
                                end else begin
                                    digitValid_q[i]    <= 1'b0;
                                    digitBlank_q[i]    <= 1'b0;
                                end
                            end
                        end
                        if (&seen_d) begin
                            frameDone_q <= 1'b1;
                            seen_q      <= '0;
                        end else begin
                            seen_q      <= seen_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                HELD: begin
                    if (!sameSample) begin
                        if (isOneHot) begin
                            state_q <= SETTLE;
                            cnt_q   <= 8'd1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SEVENSEG_ERR_CNT_EN
    logic [7:0] errCount_q;

    // Saturating count of illegal-glyph captures; a clear coinciding with an error leaves 1
    always_ff @(posedge clk) begin
        if (reset) begin
            errCount_q <= 8'd0;
        end else if (err_clr) begin
            errCount_q <= (captureNow && glyphIllegal) ? 8'd1 : 8'd0;
        end else if (captureNow && glyphIllegal && (errCount_q != 8'hFF)) begin
            errCount_q <= errCount_q + 8'd1;
        end
    end

    assign err_count = errCount_q;
`endif

    assign digits      = digits_q;
    assign digit_valid = digitValid_q;
    assign digit_blank = digitBlank_q;
    assign capture     = capture_q;
    assign capture_idx = captureIdx_q;
    assign frame_done  = frameDone_q;
    assign pattern_err = patternErr_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Testbench for sevenseg_scan_decoder: directed vector table, multi-cycle
// corner sequences, and randomized traffic checked against a run-length model.
`timescale 1ns/1ps
module tb_sevenseg_scan_decoder;

    localparam int N = 4;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [6:0]     segN;
    logic [N-1:0]   anN;
    logic [4*N-1:0] digits;
    logic [N-1:0]   digitValid;
    logic [N-1:0]   digitBlank;
    logic           capture;
    logic [2:0]     captureIdx;
    logic           frameDone;
    logic           patternErr;
`ifdef SEVENSEG_ERR_CNT_EN
    logic           errClr = 1'b0;
    logic [7:0]     errCount;
`endif

    int compared   = 0;
    int mismatched = 0;
    bit scoreOn    = 1'b0;

    always #5 clk = ~clk;

    sevenseg_scan_decoder #(.N_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_n       (segN),
        .an_n        (anN),
        .digits      (digits),
        .digit_valid (digitValid),
        .digit_blank (digitBlank),
        .capture     (capture),
        .capture_idx (captureIdx),
        .frame_done  (frameDone),
        .pattern_err (patternErr)
`ifdef SEVENSEG_ERR_CNT_EN
        ,
        .err_clr     (errClr),
        .err_count   (errCount)
`endif
    );

    logic [6:0] glyphTab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: a slot is captured once the same one-hot sample has been
    // seen on S+1 consecutive clock edges; the result appears on the following edge.
    logic [6:0]     lastSeg = '1;
    logic [N-1:0]   lastAn  = '1;
    int             runLen  = 1;
    logic [4*N-1:0] expDigits = '0;
    logic [N-1:0]   expValid = '0, expBlank = '0, expSeen = '0;
    logic [2:0]     expIdx = '0;
    bit             expCap = 0, expFrame = 0, expErr = 0;
`ifdef SEVENSEG_ERR_CNT_EN
    int             expErrCount = 0;
`endif

    always @(posedge clk) begin
        if (reset) begin
            expDigits = '0; expValid = '0; expBlank = '0; expSeen = '0;
            expIdx = '0; expCap = 0; expFrame = 0; expErr = 0;
            lastSeg = '1; lastAn = '1; runLen = 1;
`ifdef SEVENSEG_ERR_CNT_EN
            expErrCount = 0;
`endif
        end else begin
            expCap = 0; expFrame = 0; expErr = 0;
            if (runLen == S + 1 && $countones(~lastAn) == 1) begin
                logic [6:0] lit;
                int slot;
                bit found;
                logic [3:0] val;
                slot = 0;
                for (int i = 0; i < N; i++) if (!lastAn[i]) slot = i;
                expCap = 1;
                expIdx = 3'(slot);
                lit = ~lastSeg;
                found = 0;
                val = '0;
                for (int v = 0; v < 16; v++) begin
                    if (glyphTab[v] == lit) begin
                        found = 1;
                        val = 4'(v);
                    end
                end
                if (lit == 7'd0) begin
                    expDigits[4*slot +: 4] = 4'h0;
                    expValid[slot] = 0;
                    expBlank[slot] = 1;
                end else if (found) begin
                    expDigits[4*slot +: 4] = val;
                    expValid[slot] = 1;
                    expBlank[slot] = 0;
                end else begin
                    expValid[slot] = 0;
                    expBlank[slot] = 0;
                    expErr = 1;
                end
                expSeen[slot] = 1;
                if (&expSeen) begin
                    expFrame = 1;
                    expSeen = '0;
                end
            end
`ifdef SEVENSEG_ERR_CNT_EN
            if (errClr) expErrCount = expErr ? 1 : 0;
            else if (expErr && expErrCount < 255) expErrCount++;
`endif
            if ({segN, anN} == {lastSeg, lastAn}) begin
                if (runLen < S + 2) runLen++;
            end else begin
                runLen = 1;
            end
            lastSeg = segN;
            lastAn  = anN;
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (scoreOn) begin
            checkOutput("sb capture", 32'(capture), 32'(expCap));
            if (expCap) checkOutput("sb capture_idx", 32'(captureIdx), 32'(expIdx));
            checkOutput("sb digits", 32'(digits), 32'(expDigits));
            checkOutput("sb digit_valid", 32'(digitValid), 32'(expValid));
            checkOutput("sb digit_blank", 32'(digitBlank), 32'(expBlank));
            checkOutput("sb frame_done", 32'(frameDone), 32'(expFrame));
            checkOutput("sb pattern_err", 32'(patternErr), 32'(expErr));
`ifdef SEVENSEG_ERR_CNT_EN
            checkOutput("sb err_count", 32'(errCount), 32'(expErrCount));
`endif
        end
    end

    // Drive a sample and hold it for a number of cycles, counting captures seen
    task automatic applyStimulus(input logic [N-1:0] an, input logic [6:0] segLit, input int cycles, output int caps);
        anN  = an;
        segN = ~segLit;
        caps = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (capture) caps++;
        end
    endtask

    task automatic waitCapture(output int n, output bit got);
        got = 0;
        n   = 0;
        for (int c = 1; c <= 30 && !got; c++) begin
            @(negedge clk);
            if (capture) begin
                got = 1;
                n   = c;
            end
        end
    endtask

    typedef struct {
        logic [N-1:0] an;
        logic [6:0]   segLit;
        logic [2:0]   idx;
        logic [15:0]  digits;
        logic [3:0]   valid;
        logic [3:0]   blank;
        bit           frame;
        bit           err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int n, caps;
        bit got;

        vecs[0] = '{4'b1110, 7'b1111001, 3'd0, 16'h0003, 4'b0001, 4'b0000, 1'b0, 1'b0};
        vecs[1] = '{4'b1110, 7'b0110000, 3'd0, 16'h0001, 4'b0001, 4'b0000, 1'b0, 1'b0};
        vecs[2] = '{4'b1101, 7'b1110111, 3'd1, 16'h00A1, 4'b0011, 4'b0000, 1'b0, 1'b0};
        vecs[3] = '{4'b1011, 7'b0111101, 3'd2, 16'h0DA1, 4'b0111, 4'b0000, 1'b0, 1'b0};
        vecs[4] = '{4'b0111, 7'b1110000, 3'd3, 16'h7DA1, 4'b1111, 4'b0000, 1'b1, 1'b0};
        vecs[5] = '{4'b1011, 7'b1010101, 3'd2, 16'h7DA1, 4'b1011, 4'b0000, 1'b0, 1'b1};
        vecs[6] = '{4'b1101, 7'b0000000, 3'd1, 16'h7D01, 4'b1001, 4'b0010, 1'b0, 1'b0};
        vecs[7] = '{4'b1110, 7'b1111111, 3'd0, 16'h7D08, 4'b1001, 4'b0010, 1'b0, 1'b0};
        vecs[8] = '{4'b0111, 7'b1000111, 3'd3, 16'hFD08, 4'b1001, 4'b0010, 1'b1, 1'b0};
        vecs[9] = '{4'b1011, 7'b1001111, 3'd2, 16'hFE08, 4'b1101, 4'b0010, 1'b0, 1'b0};

        reset = 1'b1;
        segN  = '1;
        anN   = '1;
        repeat (3) @(negedge clk);
        checkOutput("reset digits", 32'(digits), 32'h0);
        checkOutput("reset digit_valid", 32'(digitValid), 32'h0);
        checkOutput("reset digit_blank", 32'(digitBlank), 32'h0);
        checkOutput("reset capture", 32'(capture), 32'h0);
        checkOutput("reset frame_done", 32'(frameDone), 32'h0);
        checkOutput("reset pattern_err", 32'(patternErr), 32'h0);
        reset   = 1'b0;
        scoreOn = 1'b1;

        // Directed vectors: each held until captured, latency and results checked
        foreach (vecs[i]) begin
            anN  = vecs[i].an;
            segN = ~vecs[i].segLit;
            waitCapture(n, got);
            checkOutput($sformatf("vec%0d captured", i), 32'(got), 32'd1);
            checkOutput($sformatf("vec%0d latency", i), 32'(n), 32'(S + 2));
            checkOutput($sformatf("vec%0d idx", i), 32'(captureIdx), 32'(vecs[i].idx));
            checkOutput($sformatf("vec%0d digits", i), 32'(digits), 32'(vecs[i].digits));
            checkOutput($sformatf("vec%0d valid", i), 32'(digitValid), 32'(vecs[i].valid));
            checkOutput($sformatf("vec%0d blank", i), 32'(digitBlank), 32'(vecs[i].blank));
            checkOutput($sformatf("vec%0d frame", i), 32'(frameDone), 32'(vecs[i].frame));
            checkOutput($sformatf("vec%0d err", i), 32'(patternErr), 32'(vecs[i].err));
`ifdef SEVENSEG_ERR_CNT_EN
            if (i == 5) checkOutput("vec5 err_count", 32'(errCount), 32'd1);
`endif
            applyStimulus(vecs[i].an, vecs[i].segLit, 4, caps);
            checkOutput($sformatf("vec%0d no recapture", i), 32'(caps), 32'd0);
        end

        // Segment bus toggling faster than the settle window never captures
        n = 0;
        for (int t = 0; t < 8; t++) begin
            applyStimulus(4'b1110, (t % 2 == 0) ? glyphTab[2] : glyphTab[5], 3, caps);
            n += caps;
        end
        checkOutput("glitch no capture", 32'(n), 32'd0);
        anN  = 4'b1110;
        segN = ~glyphTab[9];
        waitCapture(n, got);
        checkOutput("post-glitch latency", 32'(n), 32'(S + 2));
        checkOutput("post-glitch digit0", 32'(digits[3:0]), 32'h9);

        // Two digits enabled, then none: the FSM must stay idle
        applyStimulus(4'b1100, glyphTab[4], 20, caps);
        checkOutput("two enables no capture", 32'(caps), 32'd0);
        applyStimulus(4'b1111, glyphTab[4], 20, caps);
        checkOutput("no enables no capture", 32'(caps), 32'd0);

        // Reset while settling with cnt at 3 aborts the capture
        applyStimulus(4'b1110, glyphTab[6], 4, caps);
        checkOutput("pre-reset no capture", 32'(caps), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("mid-settle reset digits", 32'(digits), 32'h0);
        checkOutput("mid-settle reset valid", 32'(digitValid), 32'h0);
        checkOutput("mid-settle reset capture", 32'(capture), 32'h0);
        waitCapture(n, got);
        checkOutput("post-reset latency", 32'(n), 32'(S + 2));
        checkOutput("post-reset digit0", 32'(digits[3:0]), 32'h6);

        // Randomized traffic against the model
        for (int r = 0; r < 400; r++) begin
            logic [N-1:0] an;
            logic [N-1:0] oh;
            logic [6:0]   lit;
            int           pick;
            pick = $urandom_range(0, 9);
            oh   = 4'b0001 << $urandom_range(0, N - 1);
            if (pick < 7)       an = ~oh;
            else if (pick == 7) an = '1;
            else                an = 4'($urandom);
            pick = $urandom_range(0, 9);
            if (pick < 6)       lit = glyphTab[$urandom_range(0, 15)];
            else if (pick == 6) lit = 7'd0;
            else                lit = 7'($urandom);
`ifdef SEVENSEG_ERR_CNT_EN
            errClr = ($urandom_range(0, 15) == 0);
`endif
            applyStimulus(an, lit, $urandom_range(1, 8), caps);
        end

        scoreOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
